led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Controller that sequences the 16-LED bank on the board. It takes four raw push-buttons and synchronises them and edge-detects them. It keeps a saturating speed index and a glitch-free step timer, and runs a mode state machine that picks which LED pattern advances on each step. It replaces the fixed single-blinker top and drives the LED pins directly.

Parameters:
BASE_DIV, 12_500_000, clocks per period unit; step period = BASE_DIV * (16 - speed_index) clocks
SPEED_RESET, 3, speed_index value loaded at reset (0..15)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  reset, asynchronous, active-low
btnu  input  1  raw button: speed up (higher index = faster)
btnd  input  1  raw button: speed down
btnc  input  1  raw button: advance mode
btnl  input  1  raw button: pause/run toggle
leds  output  16  LED drive
speed_index  output  4  current speed index
mode  output  3  current mode encoding
step_tick  output  1  one-cycle strobe, asserted when a pattern step occurs

Behaviour:
- Reset: rst_n low clears all flops immediately, with no clock edge needed. Reset values:
  - leds = 0x0000, speed_index = SPEED_RESET, mode = BLINK (1), step_tick = 0, paused = 0.
  - count = 0; period_cur = BASE_DIV*(16-SPEED_RESET); all synchroniser flops = 0.
- Button path, per button: two-flop synchroniser plus one delay flop. pulse = sync & ~sync_d, one cycle wide.
  - Input high before edge 1 → sync high after edge 2 → pulse during cycle 2→3 → its effect is visible after edge 3.
  - Holding a button produces exactly one pulse.
- Speed:
  - btnu pulse increments speed_index, saturating at 15. btnd pulse decrements, saturating at 0.
  - If both pulse in the same cycle, up wins.
- Period arithmetic:
  - period_next = BASE_DIV*(16-speed_index), computed in 32 bits unsigned (default max 200_000_000).
  - period_next is combinational. period_cur is loaded only at step boundaries, so a speed change never truncates or extends the step in progress.
- Step timer, when not paused:
  - If count == period_cur-1: count <= 0, step_tick <= 1 for the next cycle, period_cur <= period_next, pattern advances.
  - Otherwise count <= count+1.
  - While paused: count holds, step_tick stays 0, leds hold.
- Mode FSM (encoding in brackets): OFF[0] → BLINK[1] → CHASE[2] → BOUNCE[3] → BAR[4] → OFF, advancing on each btnc pulse. Encodings 5-7 are unreachable and must recover to BLINK.
- Effect of a mode change:
  - Pattern state loads the new mode's initial value in the same cycle.
  - count <= 0 and period_cur <= period_next.
  - A mode change coinciding with a step completion: the mode change wins, no step_tick is issued, and the pattern takes the initial value.
- Patterns, one advance per step:
  - OFF: leds = 0x0000 always; steps still tick.
  - BLINK: initial 0x0000; toggles 0x0000 ↔ 0xFFFF.
  - CHASE: initial 0x0001; rotate left by one; 0x8000 → 0x0001.
  - BOUNCE: initial 0x0001, direction left. Shift one place in the current direction. On reaching 0x8000 the direction flips to right; on reaching 0x0001 it flips to left. Sequence: ...0x4000, 0x8000, 0x4000, ... 0x0002, 0x0001, 0x0002...
  - BAR: fill level n, 0..16, initial 0. leds = (1<<n)-1 computed at 17-bit width, so n=16 gives 0xFFFF. n increments each step; 16 → 0.
- Pause:
  - btnl pulse toggles paused.
  - Speed and mode still respond while paused.
  - A mode change while paused loads the initial pattern and stays paused.
- leds and step_tick are registered outputs; there is no combinational path from the buttons.

Test Plan:
Use BASE_DIV=4 with other parameters at default; reset period = 52 clocks.
1. Reset/blink: hold rst_n low then release → leds=0x0000, speed_index=3, mode=1. step_tick after 52 clocks with leds=0xFFFF; after 52 more, leds=0x0000.
2. Speed saturation: 13 btnu pulses → speed_index=15 after the 12th pulse and unchanged after the 13th. The current step completes at its old length, then steps are every 4 clocks. 20 btnd pulses → 0, steps every 64 clocks. Simultaneous btnu+btnd at index 5 → 6.
3. Chase wrap: one btnc → mode=2, leds=0x0001 in the same cycle as the mode update. Then 16 steps go 0x0002...0x8000, 0x0001.
4. Bounce and bar: btnc to mode 3 → 15 steps reach 0x8000, next step 0x4000. btnc to mode 4 → leds 0x0000, 0x0001, 0x0003, ... 0xFFFF, then 0x0000.
5. Pause: btnl pulse mid-step → no step_tick and leds frozen for 500 clocks. btnl again → first tick after the remaining count. btnc while paused → initial pattern shown, still frozen. Mode change on the step-completion cycle → no tick, initial pattern.
6. Async reset mid-operation: in BAR with leds=0x00FF, drop rst_n between clock edges → leds=0x0000, mode=1, speed_index=3 before the next edge.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : led_pattern_sequencer
// Function : Button-driven 16-LED pattern sequencer with speed, mode and pause.
// Revision : 1.0
// =============================================================================
module led_pattern_sequencer #(
    parameter int unsigned BASE_DIV    = 12_500_000,
    parameter int unsigned SPEED_RESET = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnu,
    input  logic        btnd,
    input  logic        btnc,
    input  logic        btnl,
    output logic [15:0] leds,
    output logic [3:0]  speed_index,
    output logic [2:0]  mode,
    output logic        step_tick
);

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_BLINK  = 3'd1,
        MODE_CHASE  = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_BAR    = 3'd4
    } mode_e;

    localparam logic [31:0] C_BASE_DIV     = 32'(BASE_DIV);
    localparam logic [3:0]  C_SPEED_RESET  = 4'(SPEED_RESET);
    localparam logic [31:0] C_PERIOD_RESET = C_BASE_DIV * (32'd16 - {28'd0, C_SPEED_RESET});

    // Button index order: 0 = up, 1 = down, 2 = advance mode, 3 = pause
    logic [3:0]  btn_raw;
    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  dly_q;
    logic [3:0]  btn_pulse;
    logic        up_pulse;
    logic        down_pulse;
    logic        adv_pulse;
    logic        pause_pulse;

    logic [3:0]  speed_q;
    logic [3:0]  speed_d;
    logic        paused_q;
    logic        paused_d;

    mode_e       mode_q;
    mode_e       mode_d;
    logic        mode_load;

    logic [31:0] period_next;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] period_q;
    logic [31:0] period_d;
    logic        step_done;
    logic        tick_q;
    logic        tick_d;

    logic [15:0] leds_q;
    logic [15:0] leds_d;
    logic        dir_q;
    logic        dir_d;
    logic [4:0]  bar_q;
    logic [4:0]  bar_d;
    logic [4:0]  bar_next;
    logic [15:0] bar_fill;

    assign btn_raw     = {btnl, btnc, btnd, btnu};
    assign btn_pulse   = sync2_q & ~dly_q;
    assign up_pulse    = btn_pulse[0];
    assign down_pulse  = btn_pulse[1];
    assign adv_pulse   = btn_pulse[2];
    assign pause_pulse = btn_pulse[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    always_comb begin
        speed_d = speed_q;
        if (up_pulse) begin
            if (speed_q != 4'hF) begin
                speed_d = speed_q + 4'd1;
            end
        end else if (down_pulse) begin
            if (speed_q != 4'h0) begin
                speed_d = speed_q - 4'd1;
            end
        end
    end

    assign paused_d    = paused_q ^ pause_pulse;
    assign period_next = C_BASE_DIV * {27'd0, 5'd16 - {1'b0, speed_q}};

    always_comb begin
        mode_d    = mode_q;
        mode_load = 1'b0;
        case (mode_q)
            MODE_OFF: begin
                if (adv_pulse) begin
                    mode_d    = MODE_BLINK;
                    mode_load = 1'b1;
                end
            end
            MODE_BLINK: begin
                if (adv_pulse) begin
                    mode_d    = MODE_CHASE;
                    mode_load = 1'b1;
                end
            end
            MODE_CHASE: begin
                if (adv_pulse) begin
                    mode_d    = MODE_BOUNCE;
                    mode_load = 1'b1;
                end
            end
            MODE_BOUNCE: begin
                if (adv_pulse) begin
                    mode_d    = MODE_BAR;
                    mode_load = 1'b1;
                end
            end
            MODE_BAR: begin
                if (adv_pulse) begin
                    mode_d    = MODE_OFF;
                    mode_load = 1'b1;
                end
            end
            default: begin
                mode_d    = MODE_BLINK;
                mode_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BLINK;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign step_done = (count_q == period_q - 32'd1);
    assign bar_next  = (bar_q == 5'd16) ? 5'd0 : bar_q + 5'd1;
    // Fill of n LEDs: shifting all-ones right by 16-n gives (1<<n)-1 for n = 0..16
    assign bar_fill  = 16'hFFFF >> (5'd16 - bar_next);

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        tick_d   = 1'b0;
        leds_d   = leds_q;
        dir_d    = dir_q;
        bar_d    = bar_q;
        if (mode_load) begin
            // A mode change restarts the step and overrides any step completing now
            count_d  = '0;
            period_d = period_next;
            dir_d    = 1'b0;
            bar_d    = '0;
            case (mode_d)
                MODE_CHASE,
                MODE_BOUNCE: leds_d = 16'h0001;
                default:     leds_d = 16'h0000;
            endcase
        end else if (!paused_q) begin
            if (step_done) begin
                count_d  = '0;
                period_d = period_next;
                tick_d   = 1'b1;
                case (mode_q)
                    MODE_BLINK: leds_d = ~leds_q;
                    MODE_CHASE: leds_d = {leds_q[14:0], leds_q[15]};
                    MODE_BOUNCE: begin
                        if (!dir_q) begin
                            leds_d = {leds_q[14:0], 1'b0};
                            if (leds_q[14]) begin
                                dir_d = 1'b1;
                            end
                        end else begin
                            leds_d = {1'b0, leds_q[15:1]};
                            if (leds_q[1]) begin
                                dir_d = 1'b0;
                            end
                        end
                    end
                    MODE_BAR: begin
                        bar_d  = bar_next;
                        leds_d = bar_fill;
                    end
                    default: leds_d = 16'h0000;
                endcase
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q  <= C_SPEED_RESET;
            paused_q <= 1'b0;
            count_q  <= '0;
            period_q <= C_PERIOD_RESET;
            tick_q   <= 1'b0;
            leds_q   <= 16'h0000;
            dir_q    <= 1'b0;
            bar_q    <= '0;
        end else begin
            speed_q  <= speed_d;
            paused_q <= paused_d;
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            leds_q   <= leds_d;
            dir_q    <= dir_d;
            bar_q    <= bar_d;
        end
    end

    assign leds        = leds_q;
    assign speed_index = speed_q;
    assign mode        = mode_q;
    assign step_tick   = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_led_pattern_sequencer
// Function : Self-checking bench for led_pattern_sequencer (BASE_DIV = 4).
// Revision : 1.0
// =============================================================================
module tb_led_pattern_sequencer;

    localparam int BASE_DIV    = 4;
    localparam int SPEED_RESET = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnu  = 1'b0;
    logic        btnd  = 1'b0;
    logic        btnc  = 1'b0;
    logic        btnl  = 1'b0;
    logic [15:0] leds;
    logic [3:0]  speed_index;
    logic [2:0]  mode;
    logic        step_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .BASE_DIV    (BASE_DIV),
        .SPEED_RESET (SPEED_RESET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btnu        (btnu),
        .btnd        (btnd),
        .btnc        (btnc),
        .btnl        (btnl),
        .leds        (leds),
        .speed_index (speed_index),
        .mode        (mode),
        .step_tick   (step_tick)
    );

    function automatic int period_of(input int s);
        return BASE_DIV * (16 - s);
    endfunction

    // Pattern shown after k steps in a mode, in closed form
    function automatic logic [15:0] exp_leds(input int md, input int k);
        int          p;
        logic [16:0] f;
        exp_leds = 16'h0000;
        case (md)
            1: exp_leds = (k % 2 == 1) ? 16'hFFFF : 16'h0000;
            2: exp_leds = 16'(1 << (k % 16));
            3: begin
                p = k % 30;
                exp_leds = 16'(1 << ((p <= 15) ? p : 30 - p));
            end
            4: begin
                f = (17'd1 << (k % 17)) - 17'd1;
                exp_leds = f[15:0];
            end
            default: exp_leds = 16'h0000;
        endcase
    endfunction

    // Reference model: a button press takes effect on the third edge after it is sampled
    logic [3:0] m_h1, m_h2, m_h3;
    logic [3:0] m_pulse;
    int         m_speed, m_mode, m_k, m_elapsed, m_len;
    logic       m_paused, m_tick;

    assign m_pulse = m_h2 & ~m_h3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h1 <= '0; m_h2 <= '0; m_h3 <= '0;
            m_speed <= SPEED_RESET; m_mode <= 1; m_k <= 0;
            m_elapsed <= 0; m_len <= period_of(SPEED_RESET);
            m_paused <= 1'b0; m_tick <= 1'b0;
        end else begin
            m_h1 <= {btnl, btnc, btnd, btnu};
            m_h2 <= m_h1;
            m_h3 <= m_h2;
            if (m_pulse[0])      m_speed <= (m_speed == 15) ? 15 : m_speed + 1;
            else if (m_pulse[1]) m_speed <= (m_speed == 0) ? 0 : m_speed - 1;
            if (m_pulse[3]) m_paused <= !m_paused;
            m_tick <= 1'b0;
            if (m_pulse[2]) begin
                m_mode <= (m_mode + 1) % 5;
                m_k <= 0; m_elapsed <= 0; m_len <= period_of(m_speed);
            end else if (!m_paused) begin
                if (m_elapsed + 1 == m_len) begin
                    m_elapsed <= 0; m_len <= period_of(m_speed);
                    m_k <= m_k + 1; m_tick <= 1'b1;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end
        end
    end

    task automatic press(input logic [3:0] which);
        int hold;
        int gap;
        hold = $urandom_range(1, 4);
        gap  = $urandom_range(3, 6);
        {btnl, btnc, btnd, btnu} = which;
        repeat (hold) @(negedge clk);
        {btnl, btnc, btnd, btnu} = 4'b0000;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_tick(input int bound, output int cyc, output logic seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < bound) begin
            @(negedge clk);
            cyc++;
            seen = step_tick;
        end
    endtask

    task automatic wait_mode(input logic [2:0] target, output logic ok);
        ok   = 1'b0;
        btnc = 1'b1;
        for (int c = 1; c <= 8 && !ok; c++) begin
            @(negedge clk);
            if (c == 2) btnc = 1'b0;
            ok = (mode == target);
        end
        btnc = 1'b0;
    endtask

    task automatic test_reset();
        int   cyc;
        logic seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({leds, speed_index, mode, step_tick} !== {16'h0000, 4'd3, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got leds=%h spd=%0d mode=%0d tick=%b, expected leds=0000 spd=3 mode=1 tick=0",
                     leds, speed_index, mode, step_tick);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 60) begin
                @(negedge clk);
                cyc++;
                seen = step_tick;
                n_tests++;
                if ({leds, speed_index, mode, step_tick} !==
                    {exp_leds(m_mode, m_k), 4'(m_speed), 3'(m_mode), m_tick}) begin
                    n_fail++;
                    $display("FAIL reset_model: got leds=%h spd=%0d mode=%0d tick=%b, expected leds=%h spd=%0d mode=%0d tick=%b",
                             leds, speed_index, mode, step_tick, exp_leds(m_mode, m_k), m_speed, m_mode, m_tick);
                end
            end
            n_tests++;
            if (!seen || cyc != 52) begin
                n_fail++;
                $display("FAIL reset_step_len: got %0d cycles (seen=%b), expected 52", cyc, seen);
            end
            n_tests++;
            if (leds !== ((j == 0) ? 16'hFFFF : 16'h0000)) begin
                n_fail++;
                $display("FAIL blink_leds step %0d: got %h, expected %h", j, leds, (j == 0) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    task automatic test_speed();
        int   cyc;
        logic seen;
        for (int i = 1; i <= 13; i++) begin
            press(4'b0001);
            if (i >= 12) begin
                n_tests++;
                if (speed_index !== 4'd15) begin
                    n_fail++;
                    $display("FAIL speed_sat_up after press %0d: got %0d, expected 15", i, speed_index);
                end
            end
        end
        wait_tick(80, cyc, seen);
        wait_tick(20, cyc, seen);
        n_tests++;
        if (!seen || cyc != 4) begin
            n_fail++;
            $display("FAIL speed15_period: got %0d cycles (seen=%b), expected 4", cyc, seen);
        end
        for (int i = 1; i <= 20; i++) press(4'b0010);
        n_tests++;
        if (speed_index !== 4'd0) begin
            n_fail++;
            $display("FAIL speed_sat_down: got %0d, expected 0", speed_index);
        end
        wait_tick(100, cyc, seen);
        wait_tick(100, cyc, seen);
        n_tests++;
        if (!seen || cyc != 64) begin
            n_fail++;
            $display("FAIL speed0_period: got %0d cycles (seen=%b), expected 64", cyc, seen);
        end
        for (int i = 1; i <= 5; i++) press(4'b0001);
        n_tests++;
        if (speed_index !== 4'd5) begin
            n_fail++;
            $display("FAIL speed_up5: got %0d, expected 5", speed_index);
        end
        press(4'b0011);
        n_tests++;
        if (speed_index !== 4'd6) begin
            n_fail++;
            $display("FAIL speed_up_wins: got %0d, expected 6", speed_index);
        end
    endtask

    task automatic test_chase();
        int          cyc;
        logic        seen;
        logic        ok;
        logic [15:0] e;
        wait_mode(3'd2, ok);
        n_tests++;
        if (!ok || leds !== 16'h0001 || step_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL chase_entry: got mode=%0d leds=%h tick=%b, expected mode=2 leds=0001 tick=0", mode, leds, step_tick);
        end
        for (int i = 0; i < 16; i++) begin
            wait_tick(100, cyc, seen);
            e = 16'h0001 << ((i + 1) % 16);
            n_tests++;
            if (!seen || leds !== e) begin
                n_fail++;
                $display("FAIL chase_step %0d: got leds=%h (seen=%b), expected %h", i + 1, leds, seen, e);
            end
        end
    endtask

    task automatic test_bounce_bar();
        int          cyc;
        logic        seen;
        logic        ok;
        logic [16:0] f;
        wait_mode(3'd3, ok);
        n_tests++;
        if (!ok || leds !== 16'h0001) begin
            n_fail++;
            $display("FAIL bounce_entry: got mode=%0d leds=%h, expected mode=3 leds=0001", mode, leds);
        end
        for (int i = 1; i <= 16; i++) begin
            wait_tick(100, cyc, seen);
            if (i >= 15) begin
                n_tests++;
                if (!seen || leds !== ((i == 15) ? 16'h8000 : 16'h4000)) begin
                    n_fail++;
                    $display("FAIL bounce_step %0d: got leds=%h (seen=%b), expected %h", i, leds, seen,
                             (i == 15) ? 16'h8000 : 16'h4000);
                end
            end
        end
        wait_mode(3'd4, ok);
        n_tests++;
        if (!ok || leds !== 16'h0000) begin
            n_fail++;
            $display("FAIL bar_entry: got mode=%0d leds=%h, expected mode=4 leds=0000", mode, leds);
        end
        for (int n = 1; n <= 17; n++) begin
            wait_tick(100, cyc, seen);
            f = (17'd1 << (n % 17)) - 17'd1;
            n_tests++;
            if (!seen || leds !== f[15:0]) begin
                n_fail++;
                $display("FAIL bar_step %0d: got leds=%h (seen=%b), expected %h", n, leds, seen, f[15:0]);
            end
        end
    endtask

    task automatic test_pause();
        int          cyc;
        int          p;
        int          exp_resume;
        logic        seen;
        logic        tick_seen;
        logic        changed;
        logic [15:0] frozen;
        p = period_of(6);
        // Pause driven after 10 cycles lands 13 counts into the step; resume costs 3 cycles of latency
        exp_resume = 3 + (p - 13);
        wait_tick(100, cyc, seen);
        repeat (10) @(negedge clk);
        btnl = 1'b1;
        @(negedge clk);
        btnl = 1'b0;
        repeat (4) @(negedge clk);
        frozen    = leds;
        tick_seen = 1'b0;
        changed   = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (step_tick) tick_seen = 1'b1;
            if (leds !== frozen) changed = 1'b1;
            n_tests++;
            if ({leds, speed_index, mode, step_tick} !==
                {exp_leds(m_mode, m_k), 4'(m_speed), 3'(m_mode), m_tick}) begin
                n_fail++;
                $display("FAIL pause_model: got leds=%h spd=%0d mode=%0d tick=%b, expected leds=%h spd=%0d mode=%0d tick=%b",
                         leds, speed_index, mode, step_tick, exp_leds(m_mode, m_k), m_speed, m_mode, m_tick);
            end
        end
        n_tests++;
        if (tick_seen || changed) begin
            n_fail++;
            $display("FAIL pause_frozen: got tick_seen=%b leds_changed=%b, expected 0 0", tick_seen, changed);
        end
        btnl = 1'b1;
        @(negedge clk);
        btnl = 1'b0;
        wait_tick(100, cyc, seen);
        n_tests++;
        if (!seen || cyc + 1 != exp_resume) begin
            n_fail++;
            $display("FAIL pause_resume: got %0d cycles to tick (seen=%b), expected %0d", cyc + 1, seen, exp_resume);
        end
        press(4'b1000);
        for (int i = 0; i < 3; i++) press(4'b0100);
        n_tests++;
        if (mode !== 3'd2 || leds !== 16'h0001) begin
            n_fail++;
            $display("FAIL paused_mode_change: got mode=%0d leds=%h, expected mode=2 leds=0001", mode, leds);
        end
        tick_seen = 1'b0;
        changed   = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (step_tick) tick_seen = 1'b1;
            if (leds !== 16'h0001) changed = 1'b1;
        end
        n_tests++;
        if (tick_seen || changed) begin
            n_fail++;
            $display("FAIL paused_after_mode: got tick_seen=%b leds_changed=%b, expected 0 0", tick_seen, changed);
        end
        press(4'b1000);
    endtask

    task automatic test_mode_on_step();
        int   cyc;
        int   p;
        logic seen;
        p = period_of(6);
        wait_tick(100, cyc, seen);
        // Raw press sampled on edge p-2 yields its pulse on edge p, the step-completion edge
        repeat (p - 3) @(negedge clk);
        btnc = 1'b1;
        @(negedge clk);
        btnc = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (mode !== 3'd3 || leds !== 16'h0001 || step_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_on_step: got mode=%0d leds=%h tick=%b, expected mode=3 leds=0001 tick=0", mode, leds, step_tick);
        end
        wait_tick(100, cyc, seen);
        n_tests++;
        if (!seen || cyc != p || leds !== 16'h0002) begin
            n_fail++;
            $display("FAIL mode_on_step_next: got %0d cycles leds=%h (seen=%b), expected %0d cycles leds=0002", cyc, leds, seen, p);
        end
    endtask

    task automatic test_async_reset();
        int   cyc;
        logic seen;
        logic ok;
        logic found;
        wait_mode(3'd4, ok);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            wait_tick(100, cyc, seen);
            found = (leds == 16'h00FF);
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL async_setup: got leds=%h mode=%0d, expected leds=00ff in mode 4", leds, mode);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({leds, speed_index, mode, step_tick} !== {16'h0000, 4'd3, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got leds=%h spd=%0d mode=%0d tick=%b, expected leds=0000 spd=3 mode=1 tick=0",
                     leds, speed_index, mode, step_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] b;
        b = 4'b0000;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            n_tests++;
            if ({leds, speed_index, mode, step_tick} !==
                {exp_leds(m_mode, m_k), 4'(m_speed), 3'(m_mode), m_tick}) begin
                n_fail++;
                $display("FAIL random_model @%0t: got leds=%h spd=%0d mode=%0d tick=%b, expected leds=%h spd=%0d mode=%0d tick=%b",
                         $time, leds, speed_index, mode, step_tick, exp_leds(m_mode, m_k), m_speed, m_mode, m_tick);
            end
            if ($urandom_range(0, 11) == 0) begin
                b[0] = ($urandom_range(0, 2) == 0);
                b[1] = ($urandom_range(0, 2) == 0);
                b[2] = ($urandom_range(0, 5) == 0);
                b[3] = ($urandom_range(0, 4) == 0);
            end
            {btnl, btnc, btnd, btnu} = b;
        end
        {btnl, btnc, btnd, btnu} = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_speed();
        test_chase();
        test_bounce_bar();
        test_pause();
        test_mode_on_step();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
